wb_rr_arbiter: RTL and testbench

- Two-master round-robin Wishbone B4 classic arbiter sharing one user-project slave port.
- Master 0 is the Caravel management Wishbone port; master 1 is an internal test/sequencer engine.
- Includes a per-transfer ack watchdog, so a hung slave returns an error instead of stalling the management core.
- Grant state goes to the mprj_io status bits for bench observation.

---
 rtl/wb_rr_arbiter_if.sv | 60 ++++++
 rtl/wb_rr_arbiter.sv | 177 +++++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_rr_arbiter_if.sv
// Bundle of Wishbone B4 classic signals around the two-master arbiter:
// both master-facing ports (m0_*, m1_*) and the shared slave port (s_*).
// The "slave" modport is the arbiter's view. It acts as the slave of both
// masters and drives the shared slave bus.
// The "master" modport is the environment's view. It drives the master
// requests and the slave responses.
interface wb_rr_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int SEL_W = DATA_W / 8;

    logic              m0_cyc_i;
    logic              m0_stb_i;
    logic              m0_we_i;
    logic [SEL_W-1:0]  m0_sel_i;
    logic [ADDR_W-1:0] m0_adr_i;
    logic [DATA_W-1:0] m0_dat_i;
    logic [DATA_W-1:0] m0_dat_o;
    logic              m0_ack_o;
    logic              m0_err_o;

    logic              m1_cyc_i;
    logic              m1_stb_i;
    logic              m1_we_i;
    logic [SEL_W-1:0]  m1_sel_i;
    logic [ADDR_W-1:0] m1_adr_i;
    logic [DATA_W-1:0] m1_dat_i;
    logic [DATA_W-1:0] m1_dat_o;
    logic              m1_ack_o;
    logic              m1_err_o;

    logic              s_cyc_o;
    logic              s_stb_o;
    logic              s_we_o;
    logic [SEL_W-1:0]  s_sel_o;
    logic [ADDR_W-1:0] s_adr_o;
    logic [DATA_W-1:0] s_dat_o;
    logic [DATA_W-1:0] s_dat_i;
    logic              s_ack_i;
    logic              s_err_i;

    modport slave (
        input  m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
        output m0_dat_o, m0_ack_o, m0_err_o,
        input  m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
        output m1_dat_o, m1_ack_o, m1_err_o,
        output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
        input  s_dat_i, s_ack_i, s_err_i
    );

    modport master (
        output m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
        input  m0_dat_o, m0_ack_o, m0_err_o,
        output m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
        input  m1_dat_o, m1_ack_o, m1_err_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
        output s_dat_i, s_ack_i, s_err_i
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Two-master round-robin Wishbone B4 classic arbiter with an ack watchdog.
// Ownership is held while the owner keeps cyc high; a strobed transfer that
// sees no ack/err for TIMEOUT cycles is aborted with err to the owner.
module wb_rr_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    wb_rr_arbiter_if.slave        bus,
    output logic [1:0]            grant_o,
    output logic                  timeout_o
);
    localparam int SEL_W = DATA_W / 8;
    localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
        OWN1  = 2'd2,
        ABORT = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            last_q, last_d;   // last-served master: 0 = m0, 1 = m1
    logic [WD_W-1:0] wd_q, wd_d;

    logic            own_cyc;
    logic            own_stb;
    logic            resp;
    logic            expire;

    logic              s_cyc, s_stb, s_we;
    logic [SEL_W-1:0]  s_sel;
    logic [ADDR_W-1:0] s_adr;
    logic [DATA_W-1:0] s_dat;
    logic [DATA_W-1:0] m0_dat, m1_dat;
    logic              m0_ack, m0_err, m1_ack, m1_err;
    logic [1:0]        grant;
    logic              tmo;

    // Control registers: FSM state, round-robin pointer, watchdog counter.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
        end
    end

    // Next-state, pointer and watchdog update; cyc drop takes priority over expiry.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        wd_d    = '0;
        own_cyc = 1'b0;
        own_stb = 1'b0;
        case (state_q)
            OWN0: begin
                own_cyc = bus.m0_cyc_i;
                own_stb = bus.m0_stb_i;
            end
            OWN1: begin
                own_cyc = bus.m1_cyc_i;
                own_stb = bus.m1_stb_i;
            end
            default: begin
                own_cyc = 1'b0;
                own_stb = 1'b0;
            end
        endcase
        resp   = bus.s_ack_i | bus.s_err_i;
        expire = (TIMEOUT > 0) && own_stb && !resp && (wd_q == WD_LAST);

        case (state_q)
            IDLE: begin
                if (bus.m0_cyc_i && bus.m1_cyc_i) begin
                    state_d = last_q ? OWN0 : OWN1;
                end else if (bus.m0_cyc_i) begin
                    state_d = OWN0;
                end else if (bus.m1_cyc_i) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                    last_d  = (state_q == OWN1);
                end else if (expire) begin
                    state_d = ABORT;
                    last_d  = (state_q == OWN1);
                end else if ((TIMEOUT > 0) && own_stb && !resp) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ABORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus steering from the registered state; ABORT reports err to the aborted master.
    always_comb begin
        s_cyc  = 1'b0;
        s_stb  = 1'b0;
        s_we   = 1'b0;
        s_sel  = '0;
        s_adr  = '0;
        s_dat  = '0;
        m0_dat = '0;
        m1_dat = '0;
        m0_ack = 1'b0;
        m0_err = 1'b0;
        m1_ack = 1'b0;
        m1_err = 1'b0;
        grant  = 2'b00;
        tmo    = 1'b0;
        case (state_q)
            OWN0: begin
                s_cyc  = bus.m0_cyc_i;
                s_stb  = bus.m0_stb_i;
                s_we   = bus.m0_we_i;
                s_sel  = bus.m0_sel_i;
                s_adr  = bus.m0_adr_i;
                s_dat  = bus.m0_dat_i;
                m0_dat = bus.s_dat_i;
                m0_ack = bus.s_ack_i;
                m0_err = bus.s_err_i;
                grant  = 2'b01;
            end
            OWN1: begin
                s_cyc  = bus.m1_cyc_i;
                s_stb  = bus.m1_stb_i;
                s_we   = bus.m1_we_i;
                s_sel  = bus.m1_sel_i;
                s_adr  = bus.m1_adr_i;
                s_dat  = bus.m1_dat_i;
                m1_dat = bus.s_dat_i;
                m1_ack = bus.s_ack_i;
                m1_err = bus.s_err_i;
                grant  = 2'b10;
            end
            ABORT: begin
                m0_err = !last_q;
                m1_err = last_q;
                tmo    = 1'b1;
            end
            default: begin
                grant = 2'b00;
            end
        endcase
    end

    assign bus.s_cyc_o  = s_cyc;
    assign bus.s_stb_o  = s_stb;
    assign bus.s_we_o   = s_we;
    assign bus.s_sel_o  = s_sel;
    assign bus.s_adr_o  = s_adr;
    assign bus.s_dat_o  = s_dat;
    assign bus.m0_dat_o = m0_dat;
    assign bus.m0_ack_o = m0_ack;
    assign bus.m0_err_o = m0_err;
    assign bus.m1_dat_o = m1_dat;
    assign bus.m1_ack_o = m1_ack;
    assign bus.m1_err_o = m1_err;
    assign grant_o      = grant;
    assign timeout_o    = tmo;
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter with a 16-cycle watchdog.
module tb_wb_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] grant;
    logic       tmo;
    int         errors = 0;
    int         checks = 0;

    wb_rr_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    wb_rr_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .bus       (bus),
        .grant_o   (grant),
        .timeout_o (tmo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m0(input logic cyc, input logic we);
        bus.m0_cyc_i = cyc;
        bus.m0_stb_i = cyc;
        bus.m0_we_i  = we;
    endtask

    task automatic set_m1(input logic cyc, input logic we);
        bus.m1_cyc_i = cyc;
        bus.m1_stb_i = cyc;
        bus.m1_we_i  = we;
    endtask

    // Entered while master g owns the bus; one acked transfer, drop, re-request.
    task automatic serve(input logic [1:0] g);
        chk("alt_grant", grant, g);
        bus.s_ack_i = 1'b1;
        #1;
        chk("alt_m0_ack", bus.m0_ack_o, g[0]);
        chk("alt_m1_ack", bus.m1_ack_o, g[1]);
        tick();
        bus.s_ack_i = 1'b0;
        if (g[0]) set_m0(1'b0, 1'b0); else set_m1(1'b0, 1'b0);
        #1;
        chk("alt_grant_hold", grant, g);
        tick();
        chk("alt_gap", grant, 2'b00);
        if (g[0]) set_m0(1'b1, 1'b0); else set_m1(1'b1, 1'b0);
        tick();
    endtask

    initial begin
        set_m0(1'b0, 1'b0);
        set_m1(1'b0, 1'b0);
        bus.m0_sel_i = 4'hF;
        bus.m0_adr_i = 32'h0;
        bus.m0_dat_i = 32'h0;
        bus.m1_sel_i = 4'hF;
        bus.m1_adr_i = 32'h0;
        bus.m1_dat_i = 32'h0;
        bus.s_dat_i  = 32'h0;
        bus.s_ack_i  = 1'b0;
        bus.s_err_i  = 1'b0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_timeout", tmo, 1'b0);
        chk("rst_s_cyc", bus.s_cyc_o, 1'b0);
        chk("rst_s_stb", bus.s_stb_o, 1'b0);
        chk("rst_m0_ack", bus.m0_ack_o, 1'b0);
        chk("rst_m1_err", bus.m1_err_o, 1'b0);
        chk("rst_s_dat", bus.s_dat_o, 32'h0);

        // m0 single read, ack two cycles after the first strobe cycle
        set_m0(1'b1, 1'b0);
        bus.m0_adr_i = 32'h0000_0100;
        #1;
        chk("rd_grant_lat", grant, 2'b00);
        tick();
        chk("rd_grant", grant, 2'b01);
        chk("rd_s_cyc", bus.s_cyc_o, 1'b1);
        chk("rd_s_adr", bus.s_adr_o, 32'h0000_0100);
        tick();
        chk("rd_no_ack", bus.m0_ack_o, 1'b0);
        tick();
        bus.s_ack_i = 1'b1;
        bus.s_dat_i = 32'hDEADBEEF;
        #1;
        chk("rd_m0_ack", bus.m0_ack_o, 1'b1);
        chk("rd_m0_dat", bus.m0_dat_o, 32'hDEADBEEF);
        chk("rd_m1_ack", bus.m1_ack_o, 1'b0);
        chk("rd_m1_dat", bus.m1_dat_o, 32'h0);
        tick();
        bus.s_ack_i = 1'b0;
        set_m0(1'b0, 1'b0);
        #1;
        chk("rd_grant_hold", grant, 2'b01);
        tick();
        chk("rd_grant_drop", grant, 2'b00);

        // Simultaneous requests right after reset, then continuous alternation
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_m0(1'b1, 1'b0);
        set_m1(1'b1, 1'b0);
        #1;
        chk("both_idle", grant, 2'b00);
        tick();
        serve(2'b01);
        serve(2'b10);
        serve(2'b01);
        serve(2'b10);
        chk("alt_final", grant, 2'b01);
        set_m0(1'b0, 1'b0);
        set_m1(1'b0, 1'b0);
        tick();
        tick();
        chk("alt_idle", grant, 2'b00);

        // m1 locked burst of 4 writes while m0 waits
        set_m1(1'b1, 1'b1);
        tick();
        chk("bu_grant", grant, 2'b10);
        set_m0(1'b1, 1'b0);
        bus.s_dat_i = 32'hCAFE_F00D;
        for (int i = 0; i < 4; i++) begin
            bus.m1_adr_i = 32'h40 + 32'(i * 4);
            bus.m1_dat_i = 32'h1000 + 32'(i);
            bus.s_ack_i  = 1'b1;
            #1;
            chk("bu_grant_held", grant, 2'b10);
            chk("bu_m1_ack", bus.m1_ack_o, 1'b1);
            chk("bu_m0_ack", bus.m0_ack_o, 1'b0);
            chk("bu_m0_dat", bus.m0_dat_o, 32'h0);
            chk("bu_s_we", bus.s_we_o, 1'b1);
            chk("bu_s_dat", bus.s_dat_o, 32'h1000 + 32'(i));
            tick();
        end
        bus.s_ack_i = 1'b0;
        set_m1(1'b0, 1'b0);
        #1;
        chk("bu_grant_last", grant, 2'b10);
        tick();
        chk("bu_gap", grant, 2'b00);
        tick();
        chk("bu_m0_after", grant, 2'b01);
        set_m0(1'b0, 1'b0);
        tick();
        tick();

        // Watchdog abort of an unacknowledged m0 write
        set_m0(1'b1, 1'b1);
        bus.m0_adr_i = 32'h0000_0200;
        tick();
        chk("wd_grant", grant, 2'b01);
        for (int k = 1; k < 16; k++) begin
            tick();
            chk("wd_early_timeout", tmo, 1'b0);
            chk("wd_early_err", bus.m0_err_o, 1'b0);
        end
        tick();
        bus.s_ack_i = 1'b1;
        #1;
        chk("wd_timeout", tmo, 1'b1);
        chk("wd_m0_err", bus.m0_err_o, 1'b1);
        chk("wd_late_ack", bus.m0_ack_o, 1'b0);
        chk("wd_m1_err", bus.m1_err_o, 1'b0);
        chk("wd_s_cyc", bus.s_cyc_o, 1'b0);
        chk("wd_s_stb", bus.s_stb_o, 1'b0);
        bus.s_ack_i = 1'b0;
        set_m0(1'b0, 1'b0);
        tick();
        chk("wd_after_grant", grant, 2'b00);
        chk("wd_after_timeout", tmo, 1'b0);
        chk("wd_after_err", bus.m0_err_o, 1'b0);

        // Owner drops cyc on the cycle the watchdog would expire
        set_m0(1'b1, 1'b0);
        tick();
        for (int k = 1; k < 16; k++) begin
            tick();
        end
        bus.m0_cyc_i = 1'b0;
        tick();
        chk("race_timeout", tmo, 1'b0);
        chk("race_err", bus.m0_err_o, 1'b0);
        chk("race_grant", grant, 2'b00);
        bus.m0_stb_i = 1'b0;
        tick();
        chk("race_timeout_next", tmo, 1'b0);

        // Reset pulse in the middle of an m1 transfer
        set_m1(1'b1, 1'b1);
        bus.m1_adr_i = 32'h0000_0300;
        bus.m1_dat_i = 32'h5555_AAAA;
        tick();
        chk("mr_grant", grant, 2'b10);
        chk("mr_s_cyc", bus.s_cyc_o, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mr_grant_rst", grant, 2'b00);
        chk("mr_s_cyc_rst", bus.s_cyc_o, 1'b0);
        chk("mr_s_adr_rst", bus.s_adr_o, 32'h0);
        chk("mr_s_dat_rst", bus.s_dat_o, 32'h0);
        chk("mr_m1_ack_rst", bus.m1_ack_o, 1'b0);
        chk("mr_m1_err_rst", bus.m1_err_o, 1'b0);
        chk("mr_timeout_rst", tmo, 1'b0);
        set_m0(1'b1, 1'b0);
        tick();
        chk("mr_m0_first", grant, 2'b01);
        set_m0(1'b0, 1'b0);
        set_m1(1'b0, 1'b0);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
